// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: funct3 codes, FSM states and
// the captured-request record.
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // The address is kept beside this record because its width is a top-level parameter.
    typedef struct packed {
        logic                   write;
        logic [2:0]             funct3;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// RV32I byte-lane steering: store byte enables and replicated data, load
// extraction with sign/zero extension. Optional trap via DMEM_MISALIGN_TRAP_EN.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]             funct3,
    input  logic [1:0]             addr_lo,
    input  logic [DMEM_DATA_W-1:0] wdata,
    input  logic [DMEM_DATA_W-1:0] rword,
    output logic [3:0]             byte_en,
    output logic [DMEM_DATA_W-1:0] wdata_lane,
    output logic                   misalign,
    output logic [DMEM_DATA_W-1:0] rdata_ext
);

    logic [1:0]             lo;
    logic [DMEM_DATA_W-1:0] shifted;
    logic                   is_half;
    logic                   is_word;

    assign is_half = (funct3 == F3_H) || (funct3 == F3_HU);
    assign is_word = (funct3 == F3_W);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Without the trap, low address bits are forced to natural alignment.
    always_comb begin
        lo         = addr_lo;
        byte_en    = 4'b0000;
        wdata_lane = wdata;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en    = 4'b0001 << lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                lo         = {addr_lo[1], 1'b0};
                byte_en    = 4'b0011 << lo;
                wdata_lane = {2{wdata[15:0]}};
            end
            F3_W: begin
                lo      = 2'b00;
                byte_en = 4'b1111;
            end
            default: ;
        endcase
    end

    assign shifted = rword >> {lo, 3'b000};

    always_comb begin
        rdata_ext = '0;
        case (funct3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_ext = {24'd0, shifted[7:0]};
            F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata_ext = {16'd0, shifted[15:0]};
            F3_W:    rdata_ext = rword;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states for the RV32I core.
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int DM_ADDRESS  = 9,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output dmem_state_t           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the sender holds its payload stable and valid high until that edge,
    // and ready never depends on valid.

    localparam int DEPTH = 1 << (DM_ADDRESS - 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    dmem_state_t           state;
    dmem_state_t           next_state;
    logic [CNT_W-1:0]      cnt;
    dmem_req_t             req_q;
    dmem_req_t             cur_req;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DM_ADDRESS-1:0] cur_addr;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     rword;
    logic [3:0]            byte_en;
    logic [DATA_W-1:0]     wdata_lane;
    logic [DATA_W-1:0]     rdata_ext;
    logic                  misalign;
    logic                  err;
    logic                  enter_resp;
    logic                  mem_we;

    // With zero wait states RESP is entered on the handshake edge itself,
    // so the live request must feed the datapath while IDLE.
    always_comb begin
        if (state == IDLE) begin
            cur_req.write  = req_write;
            cur_req.funct3 = req_funct3;
            cur_req.wdata  = req_wdata;
            cur_addr       = req_addr;
        end else begin
            cur_req  = req_q;
            cur_addr = addr_q;
        end
    end

    assign rword = mem[cur_addr[DM_ADDRESS-1:2]];

    dmem_lane_align u_lane_align (
        .funct3     (cur_req.funct3),
        .addr_lo    (cur_addr[1:0]),
        .wdata      (cur_req.wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .misalign   (misalign),
        .rdata_ext  (rdata_ext)
    );

    assign err        = f3_illegal(cur_req.funct3) || misalign;
    assign enter_resp = (next_state == RESP) && (state != RESP);
    assign mem_we     = enter_resp && reset && cur_req.write && !err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= '0;
            addr_q    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && req_valid) begin
                req_q  <= cur_req;
                addr_q <= cur_addr;
                cnt    <= CNT_LOAD;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (enter_resp) begin
                rsp_err   <= err;
                rsp_rdata <= (err || cur_req.write) ? '0 : rdata_ext;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[cur_addr[DM_ADDRESS-1:2]][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == '0) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        dbg_state = state;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// traffic against a byte-array reference model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int WAIT_CYC = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    dmem_state_t dbg_state;

    int          n_checks;
    int          n_bad;
    logic [32:0] exp_q[$];
    logic [7:0]  mem_b [512];

    dmem_responder #(
        .DATA_W      (32),
        .DM_ADDRESS  (9),
        .WAIT_CYCLES (WAIT_CYC),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dbg_state  (dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: memory as bytes, access size and extension from funct3.
    function automatic logic [32:0] model_access(input logic w, input logic [8:0] a,
                                                 input logic [31:0] wd, input logic [2:0] f3);
        int          size;
        bit          sgn;
        bit          bad;
        int          base;
        logic [31:0] v;
        size = 1; sgn = 0; bad = 0;
        case (f3)
            3'b000:  begin size = 1; sgn = 1; end
            3'b001:  begin size = 2; sgn = 1; end
            3'b010:  begin size = 4; sgn = 0; end
            3'b100:  begin size = 1; sgn = 0; end
            3'b101:  begin size = 2; sgn = 0; end
            default: bad = 1;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        if (!bad && (int'(a) % size) != 0) bad = 1;
`endif
        if (bad) return {1'b1, 32'd0};
        base = int'(a) - (int'(a) % size);
        if (w) begin
            for (int i = 0; i < size; i++) mem_b[base + i] = wd[8*i +: 8];
            return {1'b0, 32'd0};
        end
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | (32'(mem_b[base + i]) << (8 * i));
        if (sgn && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sgn && size == 2 && v[15]) v = v | 32'hFFFF_0000;
        return {1'b0, v};
    endfunction

    // driver: one full transaction, holding rsp_ready low for 'hold' cycles
    task automatic do_req(input logic w, input logic [8:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int hold,
                          output logic [31:0] rd, output logic er);
        int          lat;
        logic [32:0] exp;
        @(negedge clk);
        req_write  = w;
        req_addr   = a;
        req_wdata  = wd;
        req_funct3 = f3;
        req_valid  = 1'b1;
        lat = 0;
        while (!req_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("req_ready", req_ready, 1);
        @(posedge clk);
        exp_q.push_back(model_access(w, a, wd, f3));
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, WAIT_CYC + 1);
        rd  = rsp_rdata;
        er  = rsp_err;
        exp = exp_q.pop_front();
        check("rdata", rsp_rdata, exp[31:0]);
        check("err", rsp_err, exp[32]);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, rd);
            check("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_after", {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        n_checks   = 0;
        n_bad      = 0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        rsp_ready  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        reset = 1'b1;

        for (int i = 0; i < 128; i++) do_req(1'b1, 9'(i * 4), $urandom, F3_W, 0, rd, er);

        do_req(1'b1, 9'h010, 32'hDEADBEEF, F3_W, 0, rd, er);
        do_req(1'b0, 9'h010, 32'd0, F3_W, 0, rd, er);
        check("lw_deadbeef", rd, 32'hDEADBEEF);
        check("lw_deadbeef_err", er, 0);

        do_req(1'b1, 9'h010, 32'd0, F3_W, 0, rd, er);
        do_req(1'b1, 9'h013, 32'h0000007F, F3_B, 0, rd, er);
        do_req(1'b0, 9'h013, 32'd0, F3_B, 0, rd, er);
        check("lb_7f", rd, 32'h0000007F);
        do_req(1'b1, 9'h013, 32'h00000080, F3_B, 0, rd, er);
        do_req(1'b0, 9'h013, 32'd0, F3_B, 0, rd, er);
        check("lb_80", rd, 32'hFFFFFF80);
        do_req(1'b0, 9'h013, 32'd0, F3_BU, 0, rd, er);
        check("lbu_80", rd, 32'h00000080);

        do_req(1'b1, 9'h020, 32'd0, F3_W, 0, rd, er);
        do_req(1'b1, 9'h022, 32'h00008001, F3_H, 0, rd, er);
        do_req(1'b0, 9'h022, 32'd0, F3_H, 0, rd, er);
        check("lh_8001", rd, 32'hFFFF8001);
        do_req(1'b0, 9'h022, 32'd0, F3_HU, 0, rd, er);
        check("lhu_8001", rd, 32'h00008001);
        do_req(1'b0, 9'h020, 32'd0, F3_W, 0, rd, er);
        check("lw_80010000", rd, 32'h80010000);

        do_req(1'b0, 9'h010, 32'd0, F3_W, 5, rd, er);

        do_req(1'b1, 9'h030, 32'h5555AAAA, F3_W, 0, rd, er);
        do_req(1'b1, 9'h030, 32'h11111111, 3'b011, 0, rd, er);
        check("f3_err_flag", er, 1);
        check("f3_err_rdata", rd, 0);
        do_req(1'b0, 9'h030, 32'd0, F3_W, 0, rd, er);
        check("f3_err_nowrite", rd, 32'h5555AAAA);
        do_req(1'b0, 9'h031, 32'd0, F3_W, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("misalign_err", er, 1);
        check("misalign_rdata", rd, 0);
`else
        check("misalign_err", er, 0);
        check("misalign_rdata", rd, 32'h5555AAAA);
`endif

        // reset in the middle of a store's wait states
        do_req(1'b1, 9'h040, 32'hAAAAAAAA, F3_W, 0, rd, er);
        @(negedge clk);
        req_write  = 1'b1;
        req_addr   = 9'h040;
        req_wdata  = 32'h12345678;
        req_funct3 = F3_W;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("midwait_state", dbg_state, WAIT);
        reset = 1'b0;
        #1;
        check("midrst_req_ready", req_ready, 1);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rdata", rsp_rdata, 0);
        check("midrst_err", rsp_err, 0);
        @(negedge clk);
        reset = 1'b1;
        do_req(1'b0, 9'h040, 32'd0, F3_W, 0, rd, er);
        check("midrst_nocommit", rd, 32'hAAAAAAAA);

        for (int t = 0; t < 250; t++) begin
            do_req(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), $urandom,
                   3'($urandom_range(0, 7)), $urandom_range(0, 3), rd, er);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
